// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with an integrated write-back scoreboard and optional
//   write-through bypass. Register 0 reads as zero and can never be reserved.
//
// Ports
//   i_clk         clock, state updates on the rising edge
//   i_rst_n       asynchronous active-low reset (clears data and reservations)
//   i_rd_addr     NUM_RD packed read addresses, port i at [i*AW +: AW]
//   o_rd_data     NUM_RD packed read data, port i at [i*XLEN +: XLEN]
//   o_rd_busy     per read port: addressed register has a write pending
//   i_wr_en       write-back strobe
//   i_wr_addr     write-back destination
//   i_wr_data     write-back data
//   i_issue_en    reserve i_issue_addr for a newly issued producer
//   i_issue_addr  destination being reserved
//   i_flush       drop every reservation
//   o_busy_count  number of registers currently reserved
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  output logic [NUM_RD-1:0]      o_rd_busy,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [XLEN-1:0]        i_wr_data,
  input  logic                   i_issue_en,
  input  logic [AW-1:0]          i_issue_addr,
  input  logic                   i_flush,
  output logic [CW-1:0]          o_busy_count
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    r_busy_count;

  // Population count of a reservation vector.
  function automatic logic [CW-1:0] f_popcount(input logic [NREGS-1:0] v);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      acc = acc + {{(CW-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

  // Register data storage; writes to register 0 are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
    end else if (i_wr_en && (i_wr_addr != {AW{1'b0}})) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Next reservation state: flush > issue > write-back > hold.
  // Issue beats a same-cycle write-back to the same register because the
  // newer producer still owes a result.
  always_comb begin
    w_busy_nxt = {NREGS{1'b0}};
    for (int r = 1; r < NREGS; r++) begin
      if (i_flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if (i_issue_en && (i_issue_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (i_wr_en && (i_wr_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Reservation bits and their count. The count is taken from the same
  // next-state vector so it always equals popcount of the stored bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy       <= {NREGS{1'b0}};
      r_busy_count <= {CW{1'b0}};
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= f_popcount(w_busy_nxt);
    end
  end

  assign o_busy_count = r_busy_count;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_ra = i_rd_addr[g*AW +: AW];

    // Read mux: zero register, then same-cycle forward, then storage.
    always_comb begin
      if (w_ra == {AW{1'b0}}) begin
        w_data = {XLEN{1'b0}};
        w_busy = 1'b0;
      end else if ((BYPASS != 0) && i_wr_en && (i_wr_addr == w_ra)) begin
        // The forwarded value is the result the reservation waited for.
        w_data = i_wr_data;
        w_busy = 1'b0;
      end else begin
        w_data = r_regs[w_ra];
        w_busy = r_busy[w_ra];
      end
    end

    assign o_rd_data[g*XLEN +: XLEN] = w_data;
    assign o_rd_busy[g]              = w_busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with bypass and one without,
// both driven by the same stimulus.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic [2*AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          flush;

  logic [63:0]   rd_data_b1, rd_data_b0;
  logic [1:0]    rd_busy_b1, rd_busy_b0;
  logic [CW-1:0] cnt_b1, cnt_b0;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_b1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_b1), .o_rd_busy(rd_busy_b1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue_en(issue_en), .i_issue_addr(issue_addr), .i_flush(flush),
    .o_busy_count(cnt_b1)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_b0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_b0), .o_rd_busy(rd_busy_b0),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue_en(issue_en), .i_issue_addr(issue_addr), .i_flush(flush),
    .o_busy_count(cnt_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e1d0;
    logic [31:0] e1d1;
    logic        e1b0;
    logic        e1b1;
    logic [31:0] e0d0;
    logic [31:0] e0d1;
    logic        e0b0;
    logic        e0b1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    issue_en = 1'b0; issue_addr = 5'd0; flush = 1'b0;
  endtask

  localparam logic [31:0] D1 = 32'h1111_1111;

  initial begin
    rst_n = 1'b0;
    rd_addr = {5'd31, 5'd1};
    idle_inputs();

    // Rows: we wa wd ie ia fl ra0 ra1 | bypass d0 d1 b0 b1 | no-bypass d0 d1 b0 b1 | count
    vecs.push_back('{1'b1, 5'd1, D1,           1'b0, 5'd0, 1'b0, 5'd1, 5'd0, D1,    32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd5, 32'h11,       1'b0, 5'd0, 1'b0, 5'd1, 5'd5, D1,    32'h11, 1'b0, 1'b0, D1,   32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd5, 32'h22,       1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0, 1'b0, 32'h11, 32'h11, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0, 1'b0, 32'h22, 32'h22, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 6'd1});
    vecs.push_back('{1'b1, 5'd7, 32'h99,       1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h99, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h99, 32'h99, 1'b0, 1'b0, 32'h99, 32'h99, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd9, 32'h5,        1'b1, 5'd9, 1'b0, 5'd9, 5'd9, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h5, 32'h5, 1'b1, 1'b1, 32'h5, 32'h5, 1'b1, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 5'd9, 32'h0, 32'h5, 1'b0, 1'b1, 32'h0, 32'h5, 1'b0, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd9, 32'h0, 32'h5, 1'b0, 1'b0, 32'h0, 32'h5, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd1, 5'd2, D1,    32'h0, 1'b0, 1'b0, D1,    32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd2, D1,    32'h0, 1'b1, 1'b0, D1,    32'h0, 1'b1, 1'b0, 6'd1});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd1, 5'd2, D1,    32'h0, 1'b1, 1'b1, D1,    32'h0, 1'b1, 1'b1, 6'd2});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd3, 5'd5, 32'h0, 32'h22, 1'b1, 1'b0, 32'h0, 32'h22, 1'b1, 1'b0, 6'd3});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd1, 5'd5, D1,    32'h22, 1'b0, 1'b0, D1,   32'h22, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd2, 32'hAB,       1'b0, 5'd0, 1'b1, 5'd2, 5'd2, 32'hAB, 32'hAB, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd2, 5'd1, 32'hAB, D1,    1'b0, 1'b0, 32'hAB, D1,   1'b0, 1'b0, 6'd0});

    // Power-on reset state, before any clock edge.
    #1;
    check("por_data", rd_data_b1, 64'h0);
    check("por_busy", {62'h0, rd_busy_b1}, 64'h0);
    check("por_cnt", {58'h0, cnt_b1}, 64'h0);
    #2 rst_n = 1'b1;
    tick();

    // Table-driven vectors: apply, settle, compare, then clock.
    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      issue_en = vecs[i].ie; issue_addr = vecs[i].ia; flush = vecs[i].fl;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d_byp_d0", i), {32'h0, rd_data_b1[31:0]},  {32'h0, vecs[i].e1d0});
      check($sformatf("v%0d_byp_d1", i), {32'h0, rd_data_b1[63:32]}, {32'h0, vecs[i].e1d1});
      check($sformatf("v%0d_byp_b", i),  {62'h0, rd_busy_b1}, {62'h0, vecs[i].e1b1, vecs[i].e1b0});
      check($sformatf("v%0d_nob_d0", i), {32'h0, rd_data_b0[31:0]},  {32'h0, vecs[i].e0d0});
      check($sformatf("v%0d_nob_d1", i), {32'h0, rd_data_b0[63:32]}, {32'h0, vecs[i].e0d1});
      check($sformatf("v%0d_nob_b", i),  {62'h0, rd_busy_b0}, {62'h0, vecs[i].e0b1, vecs[i].e0b0});
      check($sformatf("v%0d_byp_cnt", i), {58'h0, cnt_b1}, {58'h0, vecs[i].ecnt});
      check($sformatf("v%0d_nob_cnt", i), {58'h0, cnt_b0}, {58'h0, vecs[i].ecnt});
      tick();
    end

    // Load every register with a nonzero value and reserve a few.
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'h0101_0101 * r;
      tick();
    end
    idle_inputs();
    issue_en = 1'b1; issue_addr = 5'd4;
    tick();
    issue_en = 1'b1; issue_addr = 5'd31;
    tick();
    idle_inputs();
    rd_addr = {5'd31, 5'd4};
    #1;
    check("load_r4", {32'h0, rd_data_b0[31:0]}, {32'h0, 32'h0404_0404});
    check("load_r31", {32'h0, rd_data_b0[63:32]}, {32'h0, 32'h1F1F_1F1F});
    check("load_busy", {62'h0, rd_busy_b1}, 64'h3);
    check("load_cnt", {58'h0, cnt_b1}, 64'd2);

    // Asynchronous reset between edges clears everything at once.
    rst_n = 1'b0;
    #1;
    check("rst_cnt_b1", {58'h0, cnt_b1}, 64'h0);
    check("rst_cnt_b0", {58'h0, cnt_b0}, 64'h0);
    for (int r = 1; r < 32; r++) begin
      rd_addr = {5'(r), 5'(r)};
      #1;
      check($sformatf("rst_r%0d_b1", r), {rd_data_b1, 62'h0, rd_busy_b1} == 128'h0 ? 64'h0 : 64'h1, 64'h0);
      check($sformatf("rst_r%0d_b0", r), {rd_data_b0, 62'h0, rd_busy_b0} == 128'h0 ? 64'h0 : 64'h1, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_addr = {5'd31, 5'd4};
    #1;
    check("post_rst_data", rd_data_b1, 64'h0);
    check("post_rst_busy", {62'h0, rd_busy_b1}, 64'h0);
    check("post_rst_cnt", {58'h0, cnt_b1}, 64'h0);

    // First edge after reset behaves normally.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h600D;
    tick();
    idle_inputs();
    #1;
    check("post_rst_write", {32'h0, rd_data_b0[31:0]}, {32'h0, 32'h600D});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated write-back scoreboard and optional write-through bypass; the next-generation replacement for the single-issue core's register file. It provides NUM_RD combinational read ports, one registered write port, a hardwired-zero register 0, and per-register pending bits. The decode/issue stage uses it to detect read-after-write hazards without a separate hazard table.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥ 4)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only
- AW (localparam), $clog2(NREGS), register address width
- CW (localparam), $clog2(NREGS+1), busy-count width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NUM_RD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NUM_RD  port i's register has a write pending
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back destination
- wr_data  in  XLEN  write-back data
- issue_en  in  1  an instruction writing issue_addr is issued this cycle
- issue_addr  in  AW  destination being reserved
- flush  in  1  squash all pending reservations
- busy_count  out  CW  number of registers currently marked pending

## Operation
- Storage: regs[NREGS] of XLEN bits; busy[NREGS] bits.
- Reset (rst_n low, asynchronous): every regs entry = 0, every busy bit = 0. Outputs then read: rd_data = 0 on all ports, rd_busy = 0, busy_count = 0. Holds while rst_n is low; clk is ignored.
- Write: on an edge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data. Writes to address 0 are discarded.
- Read port i (combinational):
  - rd_addr_i = 0 → rd_data_i = 0, rd_busy_i = 0.
  - BYPASS=1, wr_en=1, wr_addr = rd_addr_i ≠ 0 → rd_data_i = wr_data, rd_busy_i = 0.
  - Otherwise → rd_data_i = regs[rd_addr_i], rd_busy_i = busy[rd_addr_i].
- Scoreboard update (per edge, register r ≠ 0, applied in priority order):
  1. flush=1 → busy[r] ← 0 for all r. A same-cycle issue_en is ignored. A same-cycle write still updates regs.
  2. issue_en=1, issue_addr = r → busy[r] ← 1. This wins over a same-cycle write to r, because the newer producer keeps the reservation. The data is still written.
  3. wr_en=1, wr_addr = r → busy[r] ← 0.
  4. else hold.
- issue_addr = 0 never sets a busy bit; busy[0] is constant 0.
- Issue to an already-busy register keeps it busy. This is legal and is not an error.
- busy_count = popcount(busy), combinational from the registered bits. It does not reflect same-cycle issue/write. Maximum value NREGS-1.
- All read ports are independent. Any number of ports may address the same register.

## Timing
- Read latency: 0 cycles (combinational from rd_addr and, if BYPASS=1, from wr_en/wr_addr/wr_data).
- Write latency: data is visible through regs one edge after wr_en. With BYPASS=1 it is also visible in the same cycle.
- Busy set: rd_busy rises the cycle after the issue_en edge.
- Busy clear: with BYPASS=1, rd_busy falls in the write cycle itself. With BYPASS=0, it falls the cycle after the write edge.
- busy_count changes only on clock edges or at reset assertion.
- Reset asserted mid-operation clears all state immediately, including in-flight reservations. The first edge after rst_n deasserts behaves as a normal cycle.

## Test plan
- Reset: load regs 1..31 with nonzero values, pulse rst_n low between edges → all rd_data = 0, rd_busy = 0 and busy_count = 0 immediately, before any edge.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF, then issue_en=1, issue_addr=0 → rd_addr=0 returns 0 and rd_busy=0; busy_count stays 0.
- Bypass: BYPASS=1, regs[5]=0x11, wr_en=1, wr_addr=5, wr_data=0x22, rd_addr port0=port1=5 → both ports return 0x22 in the same cycle, and 0x22 after the edge. With BYPASS=0 → 0x11 in the same cycle, 0x22 after the edge.
- Scoreboard: issue r7 at cycle 0 → rd_busy=1 and busy_count=1 from cycle 1. Write r7=0x99 at cycle 3 → with BYPASS=1, rd_busy=0 and data 0x99 in cycle 3; busy_count=0 from cycle 4.
- Simultaneous events: busy[9]=1, issue r9 and write r9=0x5 on the same edge → regs[9]=0x5 and busy[9] stays 1. Issue r3 with flush on the same edge → busy_count=0 and busy[3]=0.
- Flush: issue r1, r2, r3 on consecutive cycles → busy_count=3. Assert flush → busy_count=0 next cycle, and regs are unchanged.
